// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: byte width, default
// post-reset hold-off and the launch sequencer state encoding.
package uart_tx_fifo_pkg;

    localparam int BYTE_W               = 8;
    localparam int DEFAULT_GUARD_CYCLES = 12500;

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty flags.
// The write side sees the full flag from before any same-cycle pop, so a
// write while full is refused even if a pop frees a slot on the same edge.
module uart_tx_fifo_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = BYTE_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push;
    logic             pop;

    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    // Next pointers, occupancy and flags for the state after this edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; pointers and count define validity.
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch sequencer in front of the 8N1 transmitter.
// After reset it holds off for GUARD_CYCLES so an in-flight frame in the
// (unreset) transmitter can finish, then launches one byte per txdone.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  wr_data,
    input  logic        wr_en,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow,
    input  logic        clear_ovf,
    output logic [7:0]  txbyte,
    output logic        senddata,
    input  logic        txdone,
    output logic        busy
);

    localparam int GCW = $clog2(GUARD_CYCLES + 1);

    tx_state_e        state_q, state_d;
    logic [GCW-1:0]   guard_cnt_q, guard_cnt_d;
    logic [BYTE_W-1:0] txbyte_q, txbyte_d;
    logic             senddata_q, senddata_d;
    logic             overflow_q, overflow_d;
    logic             pop;
    logic [BYTE_W-1:0] fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;

    uart_tx_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Launch sequencer: hold-off, launch head byte when idle, wait for txdone.
    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        txbyte_d    = txbyte_q;
        senddata_d  = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            ST_GUARD: begin
                if (guard_cnt_q == GCW'(GUARD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + GCW'(1);
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    txbyte_d   = fifo_rd_data;
                    senddata_d = 1'b1;
                    pop        = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (txdone) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_GUARD;
        endcase
    end

    // Sticky drop flag; a drop on the same edge as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && fifo_full) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Sequencer, launch outputs and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_GUARD;
            guard_cnt_q <= '0;
            txbyte_q    <= '0;
            senddata_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            txbyte_q    <= txbyte_d;
            senddata_q  <= senddata_d;
            overflow_q  <= overflow_d;
        end
    end

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign txbyte   = txbyte_q;
    assign senddata = senddata_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int GC    = 20;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_en = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        txdone = 1'b0;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        overflow;
    logic [7:0]  txbyte;
    logic        senddata;
    logic        busy;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .txbyte    (txbyte),
        .senddata  (senddata),
        .txdone    (txdone),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: byte queue plus "ready to launch" / "waiting" flags.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_ready;
    bit         m_wait;
    int         m_guard;
    logic [7:0] m_txbyte;
    bit         m_send;

    // Transmitter stand-in and logs.
    int         cyc;
    bit         auto_tx;
    int         tx_lat_min;
    int         tx_lat_max;
    int         tx_cd;
    logic [7:0] launch_byte[$];
    int         launch_cyc[$];
    int         txdone_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_ready  = 1'b0;
        m_wait   = 1'b0;
        m_guard  = GC;
        m_txbyte = 8'h00;
        m_send   = 1'b0;
        tx_cd    = 0;
    endtask

    // Apply one clock edge's worth of behaviour to the model using current inputs.
    task automatic model_edge();
        bit was_full;
        bit was_wait;
        bit launch;
        was_full = (mq.size() == DEPTH);
        was_wait = m_wait;
        launch   = m_ready && (mq.size() != 0);
        m_send   = launch;
        if (launch) begin
            m_txbyte = mq.pop_front();
            m_ready  = 1'b0;
            m_wait   = 1'b1;
        end
        if (was_wait && txdone) begin
            m_wait  = 1'b0;
            m_ready = 1'b1;
        end
        if (wr_en && !was_full) mq.push_back(wr_data);
        if (wr_en && was_full) m_ovf = 1'b1;
        else if (clear_ovf) m_ovf = 1'b0;
        if (m_guard > 0) begin
            m_guard--;
            if (m_guard == 0) m_ready = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("senddata", senddata, m_send);
        check("txbyte", txbyte, m_txbyte);
        check("count", count, mq.size());
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, mq.size() == 0);
        check("overflow", overflow, m_ovf);
        check("busy", busy, !m_ready || (mq.size() != 0));
    endtask

    // One clock: model update, edge, compare, then clear strobes and drive txdone.
    task automatic step();
        if (txdone) txdone_cyc.push_back(cyc);
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (senddata === 1'b1) begin
            launch_byte.push_back(txbyte);
            launch_cyc.push_back(cyc);
        end
        wr_en     = 1'b0;
        clear_ovf = 1'b0;
        txdone    = 1'b0;
        if (auto_tx) begin
            if (m_send) begin
                tx_cd = $urandom_range(tx_lat_max, tx_lat_min) - 1;
            end else if (tx_cd > 0) begin
                tx_cd--;
                if (tx_cd == 0) txdone = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        clear_ovf = 1'b0;
        txdone    = 1'b0;
        auto_tx   = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic clear_logs();
        launch_byte.delete();
        launch_cyc.delete();
        txdone_cyc.delete();
    endtask

    initial begin
        int wr_cyc;
        int n_early;
        tx_lat_min = 2;
        tx_lat_max = 2;
        auto_tx    = 1'b0;
        #2;

        // 1: reset state, guard hold-off, single-byte latency.
        apply_reset();
        repeat (GC) step();
        check("t1_idle_after_guard", busy, 1'b0);
        clear_logs();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        wr_cyc  = cyc;
        step();
        check("t1_no_send_cycle1", senddata, 1'b0);
        step();
        check("t1_send_cycle2", senddata, 1'b1);
        check("t1_txbyte", txbyte, 8'hA5);
        check("t1_count_zero", count, 0);
        check("t1_latency", launch_cyc.size() > 0 ? launch_cyc[0] - wr_cyc : -1, 2);
        step();
        check("t1_one_cycle_pulse", senddata, 1'b0);
        txdone = 1'b1;
        step();
        step();

        // 2: burst of four, transmitter returns txdone 100 cycles after launch.
        clear_logs();
        auto_tx    = 1'b1;
        tx_lat_min = 100;
        tx_lat_max = 100;
        for (int b = 1; b <= 4; b++) begin
            wr_en   = 1'b1;
            wr_data = 8'(b);
            step();
        end
        for (int i = 0; i < 1000 && launch_byte.size() < 4; i++) step();
        check("t2_nlaunch", launch_byte.size(), 4);
        for (int i = 0; i < launch_byte.size(); i++) begin
            check("t2_order", launch_byte[i], i + 1);
            if (i > 0 && i - 1 < txdone_cyc.size())
                check("t2_txdone_to_send", launch_cyc[i] - txdone_cyc[i - 1], 2);
        end
        check("t2_empty_after_last_pop", empty, 1'b1);
        for (int i = 0; i < 300 && busy !== 1'b0; i++) step();
        check("t2_idle", busy, 1'b0);
        auto_tx = 1'b0;

        // 3: overfill while the transmitter never finishes.
        wr_en   = 1'b1;
        wr_data = 8'h10;
        step();
        step();
        step();
        for (int i = 0; i <= DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            step();
            if (i == DEPTH - 1) begin
                check("t3_full", full, 1'b1);
                check("t3_no_ovf_yet", overflow, 1'b0);
            end
        end
        check("t3_ovf_set", overflow, 1'b1);
        check("t3_count_depth", count, DEPTH);
        clear_ovf = 1'b1;
        step();
        check("t3_ovf_cleared", overflow, 1'b0);
        wr_en     = 1'b1;
        clear_ovf = 1'b1;
        step();
        check("t3_set_beats_clear", overflow, 1'b1);

        // 4: write while full on the same edge as a pop.
        txdone = 1'b1;
        step();
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        step();
        check("t4_send", senddata, 1'b1);
        check("t4_count", count, DEPTH - 1);
        check("t4_ovf", overflow, 1'b1);

        // 5: drain, then txdone in IDLE with an empty FIFO is ignored.
        auto_tx    = 1'b1;
        tx_lat_min = 2;
        tx_lat_max = 10;
        txdone     = 1'b1;
        step();
        for (int i = 0; i < 2000 && busy !== 1'b0; i++) step();
        auto_tx = 1'b0;
        check("t5_drained", busy, 1'b0);
        txdone = 1'b1;
        step();
        repeat (3) begin
            check("t5_no_send", senddata, 1'b0);
            step();
        end
        check("t5_still_idle", busy, 1'b0);

        // Random traffic with a random-latency transmitter and stray txdone.
        auto_tx    = 1'b1;
        tx_lat_min = 2;
        tx_lat_max = 30;
        for (int i = 0; i < 1500; i++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_data   = 8'($urandom);
            clear_ovf = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) txdone = 1'b1;
            step();
        end
        auto_tx = 1'b0;

        // 6: reset during WAIT with three bytes queued, then guard hold-off.
        apply_reset();
        repeat (GC) step();
        for (int b = 0; b < 4; b++) begin
            wr_en   = 1'b1;
            wr_data = 8'h30 + 8'(b);
            step();
        end
        step();
        check("t6_three_queued", count, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_async_count", count, 0);
        check("t6_async_send", senddata, 1'b0);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = 0;
        n_early = 0;
        clear_logs();
        for (int i = 0; i < GC; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            step();
            if (senddata !== 1'b0) n_early++;
        end
        check("t6_no_early_send", n_early, 0);
        step();
        check("t6_first_launch", senddata, 1'b1);
        check("t6_launch_cycle", launch_cyc.size() > 0 ? launch_cyc[0] : -1, GC + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
